// File: rtl/mode_sequencer.sv
// mode_sequencer: synchronises and debounces the raw check button, steps the
// mode index 0..NUM_MODES-1 once per debounced press, and produces the flick
// blink phase for the setting modes.
// Optional macro MODE_SEQ_TIMEOUT_EN: adds an idle counter clocked by tick that
// returns the mode to 0 after TIMEOUT_TICKS ticks without a mode change.
module mode_sequencer #(
  parameter int NUM_MODES     = 6,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int BLINK_DIV     = 8,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       check,
  input  logic       tick,
  output logic [2:0] mode,
  output logic       flick,
  output logic       mode_chg,
  output logic       timeout_evt
);

  localparam int DBW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int BKW = $clog2(BLINK_DIV) + 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [BKW-1:0] BK_LAST   = BKW'(BLINK_DIV - 1);
  localparam logic [2:0]     MODE_LAST = 3'(NUM_MODES - 1);

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           db_q, db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_prev_q, db_prev_d;
  logic [2:0]     mode_q, mode_d;
  logic           flick_q, flick_d;
  logic [BKW-1:0] blink_cnt_q, blink_cnt_d;
  logic           mode_chg_q, mode_chg_d;
  logic           press;
  logic           timeout_fire;

  // Synchroniser shift and debounce counter: db follows s2 only after
  // DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    s1_d      = check;
    s2_d      = s1_q;
    db_d      = db_q;
    db_cnt_d  = '0;
    db_prev_d = db_q;
    if (s2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d     = s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press = db_q & ~db_prev_q;

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam int IDW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [IDW-1:0] ID_LAST = IDW'(TIMEOUT_TICKS - 1);

  logic [IDW-1:0] idle_cnt_q, idle_cnt_d;
  logic           timeout_evt_q;

  // A press on the same edge as the final tick wins over the auto-return.
  assign timeout_fire = tick & (mode_q != '0) & (idle_cnt_q == ID_LAST) & ~press;

  // Idle tick counter, cleared by any mode change and held at 0 in mode 0.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (press || timeout_fire || (mode_q == '0)) begin
      idle_cnt_d = '0;
    end else if (tick) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Idle counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q    <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      timeout_evt_q <= timeout_fire;
    end
  end

  assign timeout_evt = timeout_evt_q;
`else
  logic unused_cfg;
  assign unused_cfg   = tick ^ (TIMEOUT_TICKS < 1);
  assign timeout_fire = 1'b0;
  assign timeout_evt  = 1'b0;
`endif

  // Mode stepping, change pulse and blink phase generation.
  always_comb begin
    mode_d      = mode_q;
    mode_chg_d  = press | timeout_fire;
    flick_d     = flick_q;
    blink_cnt_d = blink_cnt_q;
    if (press) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 3'd1;
    end else if (timeout_fire) begin
      mode_d = '0;
    end
    if (mode_chg_d || (mode_q == '0)) begin
      flick_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BK_LAST) begin
      flick_d     = ~flick_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      db_q        <= 1'b0;
      db_cnt_q    <= '0;
      db_prev_q   <= 1'b0;
      mode_q      <= '0;
      flick_q     <= 1'b1;
      blink_cnt_q <= '0;
      mode_chg_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      db_prev_q   <= db_prev_d;
      mode_q      <= mode_d;
      flick_q     <= flick_d;
      blink_cnt_q <= blink_cnt_d;
      mode_chg_q  <= mode_chg_d;
    end
  end

  assign mode     = mode_q;
  assign flick    = flick_q;
  assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios with literal expectations plus
// randomized button/tick/reset traffic checked every cycle against a
// behavioural model. Honours MODE_SEQ_TIMEOUT_EN when defined.
module tb_mode_sequencer;

  localparam int NM  = 6;
  localparam int DEB = 4;
  localparam int BD  = 8;
  localparam int TT  = 10;

  logic       clk, rst, check, tick;
  logic [2:0] mode;
  logic       flick, mode_chg, timeout_evt;

  mode_sequencer #(
    .NUM_MODES    (NM),
    .DEBOUNCE_CYC (DEB),
    .BLINK_DIV    (BD),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .check      (check),
    .tick       (tick),
    .mode       (mode),
    .flick      (flick),
    .mode_chg   (mode_chg),
    .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int chg_cnt = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: button path as sample history, mode as modular count,
  // flick derived from elapsed cycles since the last mode change.
  bit m_s1, m_s2, m_db, m_dbp;
  bit run_q[$];
  int m_mode, m_since, m_ticks;
  bit m_chg, m_evt;

  task automatic model_step();
    bit pr, fire;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0;
      run_q.delete();
      m_mode = 0; m_since = 0; m_ticks = 0; m_chg = 0; m_evt = 0;
      return;
    end
    pr    = m_db && !m_dbp;
    m_dbp = m_db;
    if (m_s2 == m_db) run_q.delete();
    else begin
      run_q.push_back(m_s2);
      if (run_q.size() >= DEB) begin
        m_db = m_s2;
        run_q.delete();
      end
    end
    m_s2 = m_s1;
    m_s1 = check;
    fire = 0;
`ifdef MODE_SEQ_TIMEOUT_EN
    fire = !pr && tick && (m_mode != 0) && (m_ticks + 1 == TT);
`endif
    m_chg = pr || fire;
    m_evt = fire;
    if (pr) m_mode = (m_mode + 1) % NM;
    else if (fire) m_mode = 0;
    if (m_chg) begin
      m_since = 0;
      m_ticks = 0;
    end else begin
      m_since++;
      if (tick && m_mode != 0) m_ticks++;
    end
  endtask

  function automatic int exp_flick();
    if (m_mode == 0) return 1;
    return ((m_since / BD) % 2 == 0) ? 1 : 0;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    model_step();
    if (rst) started = 1;
    #1;
    if (started) begin
      chk("mdl_mode", mode, m_mode);
      chk("mdl_flick", flick, exp_flick());
      chk("mdl_mode_chg", mode_chg, m_chg);
      chk("mdl_timeout_evt", timeout_evt, m_evt);
      if (mode_chg === 1'b1) chg_cnt++;
    end
  end

  // Hold check high for hi edges then low for lo edges; lat = edge index
  // (0 = first high sample) of the first mode_chg pulse, -1 if none.
  task automatic press_lat(input int hi, input int lo, output int lat);
    lat = -1;
    @(negedge clk); check = 1'b1;
    for (int e = 0; e < hi; e++) begin
      @(posedge clk); #1;
      if (mode_chg === 1'b1 && lat < 0) lat = e;
    end
    @(negedge clk); check = 1'b0;
    for (int e = 0; e < lo; e++) begin
      @(posedge clk); #1;
      if (mode_chg === 1'b1 && lat < 0) lat = e + hi;
    end
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  int lat, c0, hold;
  bit lvl, found;
  int exp_seq[6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    rst = 1'b1; check = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mode", mode, 0);
    chk("rst_flick", flick, 1);
    chk("rst_mode_chg", mode_chg, 0);
    chk("rst_timeout_evt", timeout_evt, 0);
    rst = 1'b0;
    c0 = chg_cnt;
    repeat (50) @(negedge clk);
    chk("idle_mode", mode, 0);
    chk("idle_flick", flick, 1);
    chk("idle_pulses", chg_cnt - c0, 0);

    // Full cycle of clean presses.
    for (int p = 0; p < 6; p++) begin
      c0 = chg_cnt;
      press_lat(10, 10, lat);
      chk("press_lat", lat, 6);
      chk("press_mode", mode, exp_seq[p]);
      @(negedge clk);
      chk("press_pulses", chg_cnt - c0, 1);
    end

    // Glitch, then a held press with a short dropout.
    c0 = chg_cnt;
    press_lat(3, 10, lat);
    chk("glitch_lat", lat, -1);
    press_lat(10, 3, lat);
    chk("held_lat", lat, 6);
    press_lat(10, 10, lat);
    chk("dropout_lat", lat, -1);
    chk("glitch_mode", mode, 1);
    @(negedge clk);
    chk("glitch_pulses", chg_cnt - c0, 1);

    // Blink pattern after entering mode 1.
    for (int p = 0; p < 5; p++) press_lat(10, 10, lat);
    chk("wrap_mode", mode, 0);
    @(negedge clk); check = 1'b1;
    found = 0;
    for (int e = 0; e < 20 && !found; e++) begin
      @(posedge clk); #1;
      if (mode_chg === 1'b1) found = 1;
    end
    chk("blink_enter", found, 1);
    chk("blink_mode", mode, 1);
    for (int k = 0; k < 24; k++) begin
      chk("blink_flick", flick, (k < 8 || k >= 16) ? 1 : 0);
      @(posedge clk); #1;
      if (k == 3) check = 1'b0;
    end
    for (int p = 0; p < 5; p++) press_lat(10, 10, lat);
    chk("blink_back_mode", mode, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("mode0_flick", flick, 1);
    end

    // Timeout after TT ticks in mode 2.
    press_lat(10, 10, lat);
    press_lat(10, 10, lat);
    chk("to_start_mode", mode, 2);
    for (int i = 1; i <= TT; i++) begin
      @(negedge clk); tick = 1'b1;
      @(posedge clk); #1;
      if (i == TT) begin
`ifdef MODE_SEQ_TIMEOUT_EN
        chk("to_mode", mode, 0);
        chk("to_evt", timeout_evt, 1);
        chk("to_chg", mode_chg, 1);
`else
        chk("to_mode", mode, 2);
        chk("to_evt", timeout_evt, 0);
        chk("to_chg", mode_chg, 0);
`endif
      end
      @(negedge clk); tick = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("to_evt_width", timeout_evt, 0);

    // Press landing on the final tick edge wins.
    for (int i = 0; i < 8 && mode != 3'd2; i++) press_lat(10, 10, lat);
    chk("race_start_mode", mode, 2);
    for (int i = 1; i < TT; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
    end
    @(negedge clk); check = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1;
    chk("race_mode", mode, 3);
    chk("race_chg", mode_chg, 1);
    chk("race_evt", timeout_evt, 0);
    @(negedge clk); tick = 1'b0;
    repeat (6) @(negedge clk);
    check = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized traffic with occasional reset.
    hold = 0; lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        lvl  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      check = lvl;
      hold--;
      tick = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); rst = 1'b0; tick = 1'b0; check = 1'b0;

    // Reset while the button is held in mode 4.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int p = 0; p < 4; p++) press_lat(10, 10, lat);
    chk("mid_start_mode", mode, 4);
    @(negedge clk); check = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_flick", flick, 1);
    @(negedge clk); rst = 1'b0;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (mode_chg === 1'b1 && lat < 0) lat = e;
    end
    chk("mid_lat", lat, 6);
    chk("mid_mode", mode, 1);
    @(negedge clk); check = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
